drr_input_arbiter: RTL



---
 rtl/drr_arb_pkg.sv | 22 ++
 rtl/drr_deficit_bank.sv | 40 ++++
 rtl/small_fifo.sv | 48 ++++
 rtl/drr_input_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/drr_arb_pkg.sv
// rtl/drr_arb_pkg.sv - shared constants, state encoding and helpers for the DRR input arbiter
package drr_arb_pkg;

    localparam logic [7:0] IOQ_HDR_CTRL       = 8'hFF;
    localparam int         IOQ_BYTE_LEN_POS   = 0;
    localparam int         IOQ_BYTE_LEN_WIDTH = 16;

    typedef enum logic [0:0] {
        SELECT = 1'b0,
        WR_PKT = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/drr_deficit_bank.sv
// rtl/drr_deficit_bank.sv - per-queue deficit counters with saturating add, subtract and clear
module drr_deficit_bank #(
    parameter int NUM_QUEUES    = 8,
    parameter int QUANTUM_WIDTH = 16,
    parameter int DEFICIT_WIDTH = 18,
    parameter int SEL_WIDTH     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_WIDTH-1:0]     sel,
    input  logic                     add_en,
    input  logic                     sub_en,
    input  logic                     clr_en,
    input  logic [QUANTUM_WIDTH-1:0] add_val,
    input  logic [DEFICIT_WIDTH-1:0] sub_val,
    output logic [DEFICIT_WIDTH-1:0] deficit_cur
);

    logic [DEFICIT_WIDTH-1:0] deficit_q [NUM_QUEUES];
    logic [DEFICIT_WIDTH:0]   sum;
    logic [DEFICIT_WIDTH-1:0] sat_sum;

    assign deficit_cur = deficit_q[sel];
    assign sum         = {1'b0, deficit_q[sel]} + (DEFICIT_WIDTH + 1)'(add_val);
    assign sat_sum     = sum[DEFICIT_WIDTH] ? '1 : sum[DEFICIT_WIDTH-1:0];

    // Subtraction never underflows: the caller only subtracts a length it has compared against the deficit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_QUEUES; i++) deficit_q[i] <= '0;
        end else if (clr_en) begin
            deficit_q[sel] <= '0;
        end else if (add_en) begin
            deficit_q[sel] <= sat_sum;
        end else if (sub_en) begin
            deficit_q[sel] <= deficit_q[sel] - sub_val;
        end
    end

endmodule

// File: rtl/small_fifo.sv
// rtl/small_fifo.sv - small show-ahead fifo; dout presents the head word while not empty
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int CNT_W = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]          count;
    logic                      do_wr;
    logic                      do_rd;

    assign empty       = (count == '0);
    assign nearly_full = (count >= CNT_W'(DEPTH - 1));
    assign do_wr       = wr_en && (count != CNT_W'(DEPTH));
    assign do_rd       = rd_en && !empty;
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/drr_input_arbiter.sv
// rtl/drr_input_arbiter.sv - merges NUM_QUEUES rx packet streams, packet round-robin or byte-fair DRR
module drr_input_arbiter
    import drr_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 8,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int QUANTUM_WIDTH   = 16,
    parameter int DEFICIT_WIDTH   = 18,
    parameter int STAGE_NUMBER    = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0]    in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]    in_ctrl,
    input  logic [NUM_QUEUES-1:0]               in_wr,
    output logic [NUM_QUEUES-1:0]               in_rdy,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [CTRL_WIDTH-1:0]               out_ctrl,
    output logic                                out_wr,
    input  logic                                out_rdy,
    input  logic                                cfg_drr_en,
    input  logic [NUM_QUEUES*QUANTUM_WIDTH-1:0] cfg_quantum,
    output logic [clog2(NUM_QUEUES)-1:0]        cur_queue_o,
    output logic                                eop
);

    localparam int QW = clog2(NUM_QUEUES);
    localparam int FW = DATA_WIDTH + CTRL_WIDTH;

    logic [FW-1:0]            fifo_dout [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]    fifo_empty;
    logic [NUM_QUEUES-1:0]    fifo_nearly_full;
    logic [NUM_QUEUES-1:0]    rd_en;

    arb_state_t               state, state_next;
    logic [QW-1:0]            cur_queue, cur_next, next_queue;
    logic                     visit, visit_next;
    logic                     drr_mode, drr_mode_next;
    logic                     seen_data, seen_data_next;
    logic                     wr_next, first_word, eop_next;
    logic                     def_add, def_sub, def_clr;
    logic [DEFICIT_WIDTH-1:0] deficit_cur;
    logic [DATA_WIDTH-1:0]    head_data;
    logic [CTRL_WIDTH-1:0]    head_ctrl;
    logic [DEFICIT_WIDTH-1:0] head_len;
    logic                     cur_empty;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_fifo
        small_fifo #(
            .WIDTH          (FW),
            .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .din         ({in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH], in_data[g*DATA_WIDTH +: DATA_WIDTH]}),
            .wr_en       (in_wr[g]),
            .rd_en       (rd_en[g]),
            .dout        (fifo_dout[g]),
            .nearly_full (fifo_nearly_full[g]),
            .empty       (fifo_empty[g])
        );
    end

    drr_deficit_bank #(
        .NUM_QUEUES    (NUM_QUEUES),
        .QUANTUM_WIDTH (QUANTUM_WIDTH),
        .DEFICIT_WIDTH (DEFICIT_WIDTH),
        .SEL_WIDTH     (QW)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .sel         (cur_queue),
        .add_en      (def_add),
        .sub_en      (def_sub),
        .clr_en      (def_clr),
        .add_val     (cfg_quantum[cur_queue*QUANTUM_WIDTH +: QUANTUM_WIDTH]),
        .sub_val     (head_len),
        .deficit_cur (deficit_cur)
    );

    assign in_rdy      = ~fifo_nearly_full;
    assign cur_queue_o = cur_queue;
    assign cur_empty   = fifo_empty[cur_queue];
    assign head_data   = fifo_dout[cur_queue][DATA_WIDTH-1:0];
    assign head_ctrl   = fifo_dout[cur_queue][FW-1:DATA_WIDTH];
    assign next_queue  = (cur_queue == QW'(NUM_QUEUES - 1)) ? '0 : cur_queue + 1'b1;
    // A head word without an IOQ header costs nothing, so such packets are always eligible.
    assign head_len    = (head_ctrl == CTRL_WIDTH'(IOQ_HDR_CTRL))
                       ? DEFICIT_WIDTH'(head_data[IOQ_BYTE_LEN_POS +: IOQ_BYTE_LEN_WIDTH]) : '0;

    always_comb begin
        state_next     = state;
        cur_next       = cur_queue;
        visit_next     = visit;
        drr_mode_next  = drr_mode;
        seen_data_next = seen_data;
        wr_next        = 1'b0;
        first_word     = 1'b0;
        eop_next       = 1'b0;
        def_add        = 1'b0;
        def_sub        = 1'b0;
        def_clr        = 1'b0;
        rd_en          = '0;

        case (state)
            SELECT: begin
                seen_data_next = 1'b0;
                if (cur_empty) begin
                    def_clr    = 1'b1;
                    visit_next = 1'b0;
                    if (out_rdy) cur_next = next_queue;
                end else if (!cfg_drr_en) begin
                    if (out_rdy) begin
                        wr_next       = 1'b1;
                        first_word    = 1'b1;
                        drr_mode_next = 1'b0;
                        state_next    = WR_PKT;
                    end
                end else if (!visit) begin
                    def_add    = 1'b1;
                    visit_next = 1'b1;
                end else if (head_len <= deficit_cur) begin
                    if (out_rdy) begin
                        def_sub       = 1'b1;
                        wr_next       = 1'b1;
                        first_word    = 1'b1;
                        drr_mode_next = 1'b1;
                        state_next    = WR_PKT;
                    end
                end else begin
                    visit_next = 1'b0;
                    cur_next   = next_queue;
                end
            end
            WR_PKT: begin
                if (out_rdy && !cur_empty) begin
                    wr_next = 1'b1;
                    if (head_ctrl == '0) begin
                        seen_data_next = 1'b1;
                    end else if (seen_data) begin
                        eop_next   = 1'b1;
                        state_next = SELECT;
                        // DRR keeps the queue and its visit so a further packet can use the remaining deficit.
                        if (!drr_mode) begin
                            cur_next   = next_queue;
                            visit_next = 1'b0;
                        end
                    end
                end
            end
            default: state_next = SELECT;
        endcase

        rd_en[cur_queue] = wr_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SELECT;
            cur_queue <= '0;
            visit     <= 1'b0;
            drr_mode  <= 1'b0;
            seen_data <= 1'b0;
            out_wr    <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
            eop       <= 1'b0;
        end else begin
            state     <= state_next;
            cur_queue <= cur_next;
            visit     <= visit_next;
            drr_mode  <= drr_mode_next;
            seen_data <= seen_data_next;
            out_wr    <= wr_next;
            eop       <= eop_next;
            if (wr_next) begin
                out_data <= head_data;
                out_ctrl <= first_word ? CTRL_WIDTH'(STAGE_NUMBER) : head_ctrl;
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset) (in_wr & ~in_rdy) == '0);

endmodule
